// File: rtl/gamepad_pmod_emulator.sv
// Transmit side of the gamepad Pmod serial link: latch pulse, then NUM_BITS clocked bits
// (MSB first) carrying a snapshot of the button vector, started by request or a free-running timer.
module gamepad_pmod_emulator #(
  parameter int NUM_BITS    = 12,
  parameter int HALF_PERIOD = 4,
  parameter int AUTO_PERIOD = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BITS-1:0] buttons,
  input  logic                present,
  input  logic                start,
  output logic                pmod_latch,
  output logic                pmod_clk,
  output logic                pmod_data,
  output logic                busy,
  output logic                frame_done
);

  localparam int CW    = $clog2(2*HALF_PERIOD + 1);
  localparam int BW    = $clog2(NUM_BITS + 1);
  localparam int AP_M1 = (AUTO_PERIOD > 0) ? AUTO_PERIOD - 1 : 0;
  localparam int TW    = $clog2(AP_M1 + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_BIT_LO,
    S_BIT_HI,
    S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [BW-1:0]       r_bit, w_bit_nxt;
  logic [TW-1:0]       r_timer;
  logic [NUM_BITS-1:0] r_shift, w_shift_nxt;
  logic                r_latch, r_clk, r_data, r_busy, r_done;
  logic                w_latch_nxt, w_clk_nxt, w_data_nxt, w_busy_nxt, w_done_nxt;
  logic                w_trig;

  // Auto timer free-runs from reset regardless of FSM state; stays at 0 when unused.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (AUTO_PERIOD == 0 || r_timer == TW'(AP_M1)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  assign w_trig = (AUTO_PERIOD == 0) ? start : (r_timer == TW'(AP_M1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (w_trig) begin
          w_state_nxt = S_LATCH;
          w_shift_nxt = present ? buttons : '1;
        end
      end
      S_LATCH: begin
        if (r_cnt == CW'(2*HALF_PERIOD - 1)) begin
          w_state_nxt = S_BIT_LO;
          w_cnt_nxt   = '0;
        end
      end
      S_BIT_LO: begin
        if (r_cnt == CW'(HALF_PERIOD - 1)) begin
          w_state_nxt = S_BIT_HI;
          w_cnt_nxt   = '0;
        end
      end
      S_BIT_HI: begin
        if (r_cnt == CW'(HALF_PERIOD - 1)) begin
          w_cnt_nxt = '0;
          if (r_bit == BW'(NUM_BITS - 1)) begin
            w_state_nxt = S_DONE;
          end else begin
            // Shift only on the way into BIT_LO so data never moves while pmod_clk is high.
            w_state_nxt = S_BIT_LO;
            w_bit_nxt   = r_bit + BW'(1);
            w_shift_nxt = r_shift << 1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_busy_nxt  = (w_state_nxt == S_LATCH) || (w_state_nxt == S_BIT_LO) ||
                  (w_state_nxt == S_BIT_HI);
    w_latch_nxt = (w_state_nxt == S_LATCH);
    w_clk_nxt   = (w_state_nxt == S_BIT_HI);
    w_done_nxt  = (w_state_nxt == S_DONE);
    w_data_nxt  = w_busy_nxt & w_shift_nxt[NUM_BITS-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_latch <= 1'b0;
      r_clk   <= 1'b0;
      r_data  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_latch <= w_latch_nxt;
      r_clk   <= w_clk_nxt;
      r_data  <= w_data_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  assign pmod_latch = r_latch;
  assign pmod_clk   = r_clk;
  assign pmod_data  = r_data;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule
